// File: rtl/sar_scan_core.sv
// sar_scan_core: multi-channel SAR ADC sequencer with a per-channel result register file.
// Optional build macro SAR_SCAN_AVG_EN: four conversions per channel, averaged.
module sar_scan_core #(
   parameter  int NUM_BITS      = 8,
   parameter  int NUM_CH        = 4,
   parameter  int SAMPLE_CYCLES = 2,
   localparam int CH_W          = $clog2(NUM_CH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                continuous,
   input  logic [NUM_CH-1:0]   ch_mask,
   input  logic                cmp_out,
   output logic [CH_W-1:0]     ch_sel,
   output logic                sample,
   output logic [NUM_BITS-1:0] dac_code,
   output logic                busy,
   output logic                eoc,
   output logic [NUM_BITS-1:0] result,
   output logic [CH_W-1:0]     result_ch,
   input  logic [CH_W-1:0]     rd_ch,
   output logic [NUM_BITS-1:0] rd_data
);

   localparam int SC_W  = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
   localparam int BIT_W = $clog2(NUM_BITS);

   typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, STORE} state_t;

   state_t              state_q, state_d;
   logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
   logic [NUM_BITS-1:0] dac_q, dac_d;
   logic [SC_W-1:0]     samp_q, samp_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [NUM_CH-1:0]   mask_q, mask_d;
   logic [NUM_BITS-1:0] result_q, result_d;
   logic [CH_W-1:0]     result_ch_q, result_ch_d;
   logic [NUM_BITS-1:0] rf_q [NUM_CH];
   logic                rf_we;
   logic [NUM_BITS-1:0] trial;
   logic [CH_W:0]       nxt;
`ifdef SAR_SCAN_AVG_EN
   logic [1:0]          conv_q, conv_d;
   logic [NUM_BITS+1:0] acc_q, acc_d;
   logic [NUM_BITS+1:0] sum;
`endif

   function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
      lowest_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (m[i]) lowest_ch = CH_W'(i);
   endfunction

   // Returns {found, index} of the lowest enabled channel above cur.
   function automatic logic [CH_W:0] higher_ch(input logic [NUM_CH-1:0] m,
                                               input logic [CH_W-1:0]   cur);
      higher_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (m[i] && (i > int'(cur))) higher_ch = {1'b1, CH_W'(i)};
   endfunction

   always_comb begin
      state_d     = state_q;
      ch_sel_d    = ch_sel_q;
      dac_d       = dac_q;
      samp_d      = samp_q;
      bit_d       = bit_q;
      mask_d      = mask_q;
      result_d    = result_q;
      result_ch_d = result_ch_q;
      rf_we       = 1'b0;
      trial       = dac_q;
      nxt         = higher_ch(mask_q, ch_sel_q);
`ifdef SAR_SCAN_AVG_EN
      conv_d      = conv_q;
      acc_d       = acc_q;
      sum         = acc_q + {2'b00, dac_q};
`endif
      case (state_q)
         IDLE: begin
            if (start && (ch_mask != '0)) begin
               mask_d   = ch_mask;
               ch_sel_d = lowest_ch(ch_mask);
               samp_d   = '0;
               dac_d    = '0;
               state_d  = SAMPLE;
            end
         end
         SAMPLE: begin
            if (samp_q == SC_W'(SAMPLE_CYCLES - 1)) begin
               dac_d   = {1'b1, {(NUM_BITS-1){1'b0}}};
               bit_d   = BIT_W'(NUM_BITS - 1);
               state_d = CONVERT;
            end else begin
               samp_d = samp_q + 1'b1;
            end
         end
         CONVERT: begin
            if (!cmp_out) trial[bit_q] = 1'b0;
            if (bit_q != '0) begin
               trial[bit_q - 1'b1] = 1'b1;
               bit_d = bit_q - 1'b1;
               dac_d = trial;
            end else begin
               dac_d = trial;
`ifdef SAR_SCAN_AVG_EN
               sum = acc_q + {2'b00, trial};
               if (conv_q != 2'd3) begin
                  // Not the last of four: accumulate and resample the same channel.
                  conv_d  = conv_q + 1'b1;
                  acc_d   = sum;
                  samp_d  = '0;
                  dac_d   = '0;
                  state_d = SAMPLE;
               end else begin
                  conv_d      = '0;
                  acc_d       = '0;
                  result_d    = sum[NUM_BITS+1:2];
                  result_ch_d = ch_sel_q;
                  rf_we       = 1'b1;
                  state_d     = STORE;
               end
`else
               result_d    = trial;
               result_ch_d = ch_sel_q;
               rf_we       = 1'b1;
               state_d     = STORE;
`endif
            end
         end
         STORE: begin
            if (nxt[CH_W]) begin
               ch_sel_d = nxt[CH_W-1:0];
               samp_d   = '0;
               dac_d    = '0;
               state_d  = SAMPLE;
            end else if (continuous) begin
               ch_sel_d = lowest_ch(mask_q);
               samp_d   = '0;
               dac_d    = '0;
               state_d  = SAMPLE;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ch_sel_q    <= '0;
         dac_q       <= '0;
         samp_q      <= '0;
         bit_q       <= '0;
         mask_q      <= '0;
         result_q    <= '0;
         result_ch_q <= '0;
         for (int i = 0; i < NUM_CH; i++) rf_q[i] <= '0;
`ifdef SAR_SCAN_AVG_EN
         conv_q      <= '0;
         acc_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ch_sel_q    <= ch_sel_d;
         dac_q       <= dac_d;
         samp_q      <= samp_d;
         bit_q       <= bit_d;
         mask_q      <= mask_d;
         result_q    <= result_d;
         result_ch_q <= result_ch_d;
         if (rf_we) rf_q[ch_sel_q] <= result_d;
`ifdef SAR_SCAN_AVG_EN
         conv_q      <= conv_d;
         acc_q       <= acc_d;
`endif
      end
   end

   assign ch_sel    = ch_sel_q;
   assign sample    = (state_q == SAMPLE);
   assign dac_code  = dac_q;
   assign busy      = (state_q != IDLE);
   assign eoc       = (state_q == STORE);
   assign result    = result_q;
   assign result_ch = result_ch_q;
   assign rd_data   = rf_q[rd_ch];

endmodule

// File: tb/tb_sar_scan_core.sv
// Directed bench for sar_scan_core with an ideal comparator model (vin >= dac_code).
module tb_sar_scan_core;

`ifdef SAR_SCAN_AVG_EN
   localparam int CONV = 4;
`else
   localparam int CONV = 1;
`endif
   localparam int LAT   = CONV * (2 + 8) + 1;
   localparam int LIMIT = 4 * LAT;

   logic       clk = 1'b0;
   logic       rst, start, continuous, cmp_out;
   logic [3:0] ch_mask;
   logic [1:0] ch_sel, result_ch, rd_ch;
   logic       sample, busy, eoc;
   logic [7:0] dac_code, result, rd_data;
   logic [7:0] vin [4];

   int checks   = 0;
   int failures = 0;
   int n;
   int eoc_cnt;

   sar_scan_core dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous),
      .ch_mask(ch_mask), .cmp_out(cmp_out), .ch_sel(ch_sel), .sample(sample),
      .dac_code(dac_code), .busy(busy), .eoc(eoc), .result(result),
      .result_ch(result_ch), .rd_ch(rd_ch), .rd_data(rd_data)
   );

   always #5 clk = ~clk;
   assign cmp_out = (vin[ch_sel] >= dac_code);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_scan();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_eoc(output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (!eoc && cnt < LIMIT);
   endtask

   task automatic count_eoc(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (eoc) cnt++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; continuous = 1'b0; ch_mask = '0; rd_ch = '0;
      vin[0] = 8'h00; vin[1] = 8'h00; vin[2] = 8'h00; vin[3] = 8'h00;
      do_reset();
      check("rst_busy", busy, 0);
      check("rst_eoc", eoc, 0);
      check("rst_sample", sample, 0);
      check("rst_dac", dac_code, 0);
      check("rst_result", result, 0);
      check("rst_ch_sel", ch_sel, 0);
      check("rst_rd_data", rd_data, 0);

      // Single channel 2
      ch_mask = 4'b0100; vin[2] = 8'hA5; rd_ch = 2'd2;
      start_scan();
      check("t1_sample_c1", sample, 1);
      check("t1_dac_c1", dac_code, 0);
      check("t1_busy_c1", busy, 1);
      check("t1_ch_sel", ch_sel, 2);
      tick();
      check("t1_sample_c2", sample, 1);
      tick();
      check("t1_sample_c3", sample, 0);
      check("t1_dac_msb", dac_code, 8'h80);
      wait_eoc(n);
      check("t1_latency", n, LAT - 3);
      check("t1_result", result, 8'hA5);
      check("t1_result_ch", result_ch, 2);
      check("t1_rd_data", rd_data, 8'hA5);
      tick();
      check("t1_busy_drop", busy, 0);
      check("t1_eoc_drop", eoc, 0);

      // Three-channel single pass
      do_reset();
      check("t2_rf_cleared", rd_data, 0);
      ch_mask = 4'b1011; vin[0] = 8'h00; vin[1] = 8'h3C; vin[2] = 8'h77; vin[3] = 8'hFF;
      start_scan();
      wait_eoc(n);
      check("t2_lat0", n, LAT - 1);
      check("t2_res0", result, 8'h00);
      check("t2_ch0", result_ch, 0);
      rd_ch = 2'd3;
      wait_eoc(n);
      check("t2_lat1", n, LAT);
      check("t2_res1", result, 8'h3C);
      check("t2_ch1", result_ch, 1);
      repeat (LAT - 1) tick();
      check("t2_pre_store_eoc", eoc, 0);
      check("t2_rd_old", rd_data, 0);
      tick();
      check("t2_eoc3", eoc, 1);
      check("t2_res3", result, 8'hFF);
      check("t2_ch3", result_ch, 3);
      check("t2_rd_new", rd_data, 8'hFF);
      rd_ch = 2'd2;
      #1;
      check("t2_ch2_untouched", rd_data, 0);
      tick();
      check("t2_idle", busy, 0);

      // Continuous scan, dropped during a ch0 conversion
      continuous = 1'b1; ch_mask = 4'b0011; vin[0] = 8'h55; vin[1] = 8'hC3;
      start_scan();
      wait_eoc(n);
      check("t3_lat0", n, LAT - 1);
      check("t3_ch0", result_ch, 0);
      check("t3_res0", result, 8'h55);
      wait_eoc(n);
      check("t3_lat1", n, LAT);
      check("t3_ch1", result_ch, 1);
      repeat (3) tick();
      check("t3_wrap_ch_sel", ch_sel, 0);
      continuous = 1'b0;
      wait_eoc(n);
      check("t3_lat2", n, LAT - 3);
      check("t3_ch0b", result_ch, 0);
      wait_eoc(n);
      check("t3_lat3", n, LAT);
      check("t3_ch1b", result_ch, 1);
      check("t3_res1b", result, 8'hC3);
      tick();
      check("t3_idle", busy, 0);
      count_eoc(LAT + 2, eoc_cnt);
      check("t3_no_more_eoc", eoc_cnt, 0);

      // Reset while deciding bit 4
      ch_mask = 4'b0100; vin[2] = 8'h5A; rd_ch = 2'd1;
      start_scan();
      repeat (5) tick();
      check("t4_dac_bit4", dac_code, 8'h50);
      check("t4_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t4_busy0", busy, 0);
      check("t4_sample0", sample, 0);
      check("t4_eoc0", eoc, 0);
      check("t4_dac0", dac_code, 0);
      check("t4_ch_sel0", ch_sel, 0);
      check("t4_result0", result, 0);
      check("t4_result_ch0", result_ch, 0);
      check("t4_rf0", rd_data, 0);
      count_eoc(LAT + 2, eoc_cnt);
      check("t4_no_eoc", eoc_cnt, 0);
      ch_mask = 4'b0010; vin[1] = 8'h81;
      start_scan();
      wait_eoc(n);
      check("t4_lat", n, LAT - 1);
      check("t4_res", result, 8'h81);
      check("t4_ch", result_ch, 1);
      check("t4_rd", rd_data, 8'h81);
      tick();

      // Ignored starts
      ch_mask = 4'b0000;
      start_scan();
      check("t5_mask0_busy", busy, 0);
      check("t5_mask0_sample", sample, 0);
      ch_mask = 4'b0001; vin[0] = 8'h33;
      start_scan();
      repeat (3) tick();
      ch_mask = 4'b1111;
      start_scan();
      check("t5_ch_sel_kept", ch_sel, 0);
      wait_eoc(n);
      check("t5_lat", n, LAT - 5);
      check("t5_res", result, 8'h33);
      check("t5_ch", result_ch, 0);
      tick();
      check("t5_idle", busy, 0);
      count_eoc(LAT + 2, eoc_cnt);
      check("t5_no_extra_eoc", eoc_cnt, 0);

`ifdef SAR_SCAN_AVG_EN
      // Four conversions with varying input, averaged
      ch_mask = 4'b0001; vin[0] = 8'h10;
      start_scan();
      count_eoc(10, eoc_cnt);
      n = eoc_cnt;
      vin[0] = 8'h11;
      count_eoc(10, eoc_cnt);
      n += eoc_cnt;
      vin[0] = 8'h12;
      count_eoc(10, eoc_cnt);
      n += eoc_cnt;
      vin[0] = 8'h14;
      check("avg_no_early_eoc", n, 0);
      wait_eoc(n);
      check("avg_lat", n, 10);
      check("avg_res", result, 8'h11);
      check("avg_ch", result_ch, 0);
      tick();
      check("avg_idle", busy, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
